// File: rtl/echo_detector_if.sv
// Bundles the echo detector's control, DFT-sum inputs and result outputs.
// master drives stimulus and reads results; slave is the detector side.
interface echo_detector_if #(
  parameter int unsigned TW = 24
) ();
  logic               start;
  logic               abort;
  logic        [64:0] threshold;
  logic signed [63:0] cos_sum;
  logic signed [63:0] sin_sum;
  logic               busy;
  logic               valid;
  logic               timeout;
  logic      [TW-1:0] tof;
  logic        [64:0] peak_mag;

  modport master (
    output start, abort, threshold, cos_sum, sin_sum,
    input  busy, valid, timeout, tof, peak_mag
  );

  modport slave (
    input  start, abort, threshold, cos_sum, sin_sum,
    output busy, valid, timeout, tof, peak_mag
  );
endinterface

// File: rtl/echo_detector.sv
// Time-of-flight echo detector: alpha-max/beta-min magnitude of the DFT bin,
// blanking after start, then search for the first sustained threshold crossing.
module echo_detector #(
  parameter int unsigned BLANK_CYCLES   = 2000,
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TW             = 24
) (
  input logic            clk,
  input logic            rst_n,
  echo_detector_if.slave bus
);

  localparam int unsigned RW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StBlank, StSearch} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [TW-1:0]   cand_q, cand_d;
  logic [TW-1:0]   tof_q, tof_d;
  logic [RW-1:0]   run_q, run_d;
  logic [64:0]     thr_q, thr_d;
  logic [64:0]     peak_q, peak_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;

  logic [63:0]     cos_u, sin_u, abs_cos, abs_sin;
  logic [63:0]     a_q, b_q, mx, mn;
  logic [64:0]     mag_d, mag_q;
  logic            above;

  // Two's-complement negate in 64 bits maps -2^63 to 2^63 exactly.
  always_comb begin
    cos_u   = $unsigned(bus.cos_sum);
    sin_u   = $unsigned(bus.sin_sum);
    abs_cos = cos_u[63] ? (~cos_u + 64'd1) : cos_u;
    abs_sin = sin_u[63] ? (~sin_u + 64'd1) : sin_u;
  end

  always_comb begin
    mx    = (a_q >= b_q) ? a_q : b_q;
    mn    = (a_q >= b_q) ? b_q : a_q;
    mag_d = {1'b0, mx} + {2'b00, mn[63:1]};
  end

  assign above = (mag_q > thr_q);

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    cand_d    = cand_q;
    run_d     = run_q;
    thr_d     = thr_q;
    peak_d    = peak_q;
    tof_d     = tof_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;

    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d = StBlank;
            tcnt_d  = '0;
            thr_d   = bus.threshold;
            peak_d  = '0;
            run_d   = '0;
          end
        end
        StBlank: begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == TW'(BLANK_CYCLES - 1)) state_d = StSearch;
        end
        StSearch: begin
          tcnt_d = tcnt_q + 1'b1;
          if (mag_q > peak_q) peak_d = mag_q;
          if (above) begin
            run_d = run_q + 1'b1;
            if (run_q == '0) cand_d = tcnt_q;
          end else begin
            run_d = '0;
          end
          // Detection takes priority over expiry on the final search cycle.
          if (above && (run_q == RW'(HOLD_CYCLES - 1))) begin
            valid_d = 1'b1;
            tof_d   = (run_q == '0) ? tcnt_q : cand_q;
            state_d = StIdle;
          end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tcnt_q    <= '0;
      cand_q    <= '0;
      tof_q     <= '0;
      run_q     <= '0;
      thr_q     <= '0;
      peak_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mag_q     <= '0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      cand_q    <= cand_d;
      tof_q     <= tof_d;
      run_q     <= run_d;
      thr_q     <= thr_d;
      peak_q    <= peak_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      a_q       <= abs_cos;
      b_q       <= abs_sin;
      mag_q     <= mag_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.valid    = valid_q;
  assign bus.timeout  = timeout_q;
  assign bus.tof      = tof_q;
  assign bus.peak_mag = peak_q;

endmodule

// File: tb/tb_echo_detector.sv
// Directed bench for echo_detector with BLANK=10, HOLD=3, TIMEOUT=100.
// t mirrors the DUT time counter: t=0 right after the start edge.
module tb_echo_detector;
  localparam int unsigned BLANK = 10;
  localparam int unsigned HOLD  = 3;
  localparam int unsigned TMO   = 100;
  localparam int unsigned TW    = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  echo_detector_if #(.TW(TW)) bus ();

  echo_detector #(
    .BLANK_CYCLES  (BLANK),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TMO),
    .TW            (TW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total  = 0;
  int passed = 0;
  int t, nvalid, nto, tvalid, tto;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // code 0: mag 500, 1: mag 1200, 2: mag 1000, 3: both sums -2^63
  task automatic set_mag(input int code);
    case (code)
      1:       begin bus.cos_sum = 64'sd1000; bus.sin_sum = -64'sd400; end
      2:       begin bus.cos_sum = 64'sd1000; bus.sin_sum = 64'sd0;    end
      3:       begin bus.cos_sum = 64'h8000_0000_0000_0000;
                     bus.sin_sum = 64'h8000_0000_0000_0000;           end
      default: begin bus.cos_sum = 64'sd500;  bus.sin_sum = 64'sd0;    end
    endcase
  endtask

  // Magnitude code wanted at the comparison made while tcnt == tm.
  function automatic int sched(input int scn, input int tm);
    case (scn)
      1:       return 1;
      2:       return (tm == 20 || tm == 21 || tm >= 40) ? 1 : 0;
      3:       return 2;
      4:       return 3;
      5:       return (tm >= 97) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic start_run(input logic [64:0] thr, input int scn);
    set_mag(sched(scn, 0));
    bus.threshold = thr;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t = 0; nvalid = 0; nto = 0; tvalid = -1; tto = -1;
  endtask

  // Inputs lead the comparison by the 2-cycle magnitude pipeline.
  task automatic run_cycles(input int scn, input int n);
    for (int i = 0; i < n; i++) begin
      set_mag(sched(scn, t + 2));
      @(posedge clk); #1;
      t++;
      if (bus.valid) begin
        nvalid++;
        if (tvalid < 0) tvalid = t;
      end
      if (bus.timeout) begin
        nto++;
        if (tto < 0) tto = t;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.threshold = '0;
    bus.cos_sum = '0; bus.sin_sum = '0;

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.start     = 1'($urandom_range(0, 1));
      bus.abort     = 1'($urandom_range(0, 1));
      bus.threshold = {1'b0, $urandom, $urandom};
      bus.cos_sum   = {$urandom, $urandom};
      bus.sin_sum   = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    chk("rst_busy", 65'(bus.busy), 65'd0);
    chk("rst_valid", 65'(bus.valid), 65'd0);
    chk("rst_timeout", 65'(bus.timeout), 65'd0);
    chk("rst_tof", 65'(bus.tof), 65'd0);
    chk("rst_peak", bus.peak_mag, 65'd0);
    bus.start = 1'b0; bus.abort = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", 65'(bus.busy), 65'd0);

    // Basic echo: mag 1200 > 1100
    start_run(65'd1100, 1);
    chk("basic_busy_up", 65'(bus.busy), 65'd1);
    run_cycles(1, 30);
    chk("basic_nvalid", 65'(nvalid), 65'd1);
    chk("basic_tvalid", 65'(tvalid), 65'd13);
    chk("basic_nto", 65'(nto), 65'd0);
    chk("basic_tof", 65'(bus.tof), 65'd10);
    chk("basic_peak", bus.peak_mag, 65'd1200);
    chk("basic_busy_down", 65'(bus.busy), 65'd0);

    // Run interrupted at 22, qualifying run starts at 40
    start_run(65'd1100, 2);
    run_cycles(2, 60);
    chk("runrst_nvalid", 65'(nvalid), 65'd1);
    chk("runrst_tvalid", 65'(tvalid), 65'd43);
    chk("runrst_tof", 65'(bus.tof), 65'd40);
    chk("runrst_peak", bus.peak_mag, 65'd1200);

    // Timeout: 1000 never exceeds 1100
    start_run(65'd1100, 3);
    run_cycles(3, 110);
    chk("tmo_nto", 65'(nto), 65'd1);
    chk("tmo_tto", 65'(tto), 65'd100);
    chk("tmo_nvalid", 65'(nvalid), 65'd0);
    chk("tmo_peak", bus.peak_mag, 65'd1000);
    chk("tmo_tof_kept", 65'(bus.tof), 65'd40);
    chk("tmo_busy", 65'(bus.busy), 65'd0);

    // Detection completing on the timeout cycle
    start_run(65'd1100, 5);
    run_cycles(5, 110);
    chk("edge_nvalid", 65'(nvalid), 65'd1);
    chk("edge_tvalid", 65'(tvalid), 65'd100);
    chk("edge_nto", 65'(nto), 65'd0);
    chk("edge_tof", 65'(bus.tof), 65'd97);

    // Abort during SEARCH at tcnt 15
    start_run(65'd1100, 6);
    run_cycles(6, 15);
    chk("abort_busy_pre", 65'(bus.busy), 65'd1);
    bus.abort = 1'b1;
    run_cycles(6, 1);
    bus.abort = 1'b0;
    chk("abort_busy", 65'(bus.busy), 65'd0);
    run_cycles(6, 100);
    chk("abort_nvalid", 65'(nvalid), 65'd0);
    chk("abort_nto", 65'(nto), 65'd0);
    chk("abort_tof_kept", 65'(bus.tof), 65'd97);
    chk("abort_peak_kept", bus.peak_mag, 65'd500);

    // Extreme inputs: 2^63 + 2^62
    start_run(65'd0, 4);
    run_cycles(4, 30);
    chk("ext_nvalid", 65'(nvalid), 65'd1);
    chk("ext_tvalid", 65'(tvalid), 65'd13);
    chk("ext_tof", 65'(bus.tof), 65'd10);
    chk("ext_peak", bus.peak_mag, 65'h0_C000_0000_0000_0000);

    // Second start at tcnt 5 is ignored (its huge threshold is not latched)
    start_run(65'd1100, 1);
    run_cycles(1, 5);
    bus.start = 1'b1; bus.threshold = 65'h1_FFFF_FFFF_FFFF_FFFF;
    run_cycles(1, 1);
    bus.start = 1'b0;
    run_cycles(1, 25);
    chk("restart_nvalid", 65'(nvalid), 65'd1);
    chk("restart_tvalid", 65'(tvalid), 65'd13);

    // start and abort together in IDLE
    bus.start = 1'b1; bus.abort = 1'b1; bus.threshold = 65'd1100;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_busy", 65'(bus.busy), 65'd0);
    @(posedge clk); #1;
    chk("start_abort_busy2", 65'(bus.busy), 65'd0);

    // Asynchronous reset at tcnt 5
    start_run(65'd1100, 1);
    run_cycles(1, 5);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 65'(bus.busy), 65'd0);
    chk("arst_tof", 65'(bus.tof), 65'd0);
    chk("arst_peak", bus.peak_mag, 65'd0);
    chk("arst_valid", 65'(bus.valid), 65'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nvalid = 0; nto = 0;
    run_cycles(1, 20);
    chk("arst_quiet_valid", 65'(nvalid), 65'd0);
    chk("arst_quiet_busy", 65'(bus.busy), 65'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
